// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared FSM state type, default parameters and pointer helper for uart_tx_arbiter
package uart_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_LOCK_TIMEOUT = 1024;
  typedef enum logic [2:0] {IDLE, FLUSH, WAIT_BUSY, WAIT_DONE, HOLD} arb_state_e;
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-requester byte stream bus (valid/data/last in, one-hot ready out)
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave (input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first active request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  // Walk from the farthest slot back to ptr so the nearest active slot is written last and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      cand = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      if (req[cand]) begin
        gnt = N'(1) << cand;
        idx = cand;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter feeding one byte at a time to a UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_tx_arbiter_if.slave        req,
  output logic [7:0]              tx_data,
  output logic                    tx_flush,
  input  logic                    tx_busy,
  output logic [IW-1:0]           grant_id,
  output logic                    grant_active,
  output logic                    lock_timeout
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic grant_active_q, grant_active_d;
  logic [7:0] data_q, data_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lock_timeout_q, lock_timeout_d;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0] arb_idx;
  logic arb_any;
  logic [N_REQ-1:0][7:0] bytes;
  assign bytes = req.req_data;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (req.req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );
  assign tx_flush = state_q == FLUSH;
  assign tx_data = data_q;
  assign grant_id = grant_id_q;
  assign grant_active = grant_active_q;
  assign lock_timeout = lock_timeout_q;
  // Next-state and ready decode; ready is only ever driven from IDLE (arbitrated) or HOLD (owner only).
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    grant_active_d = grant_active_q;
    data_d = data_q;
    last_d = last_q;
    cnt_d = cnt_q;
    lock_timeout_d = 1'b0;
    req.req_ready = '0;
    case (state_q)
      IDLE: if (!tx_busy && arb_any) begin
        req.req_ready = arb_gnt;
        data_d = bytes[arb_idx];
        last_d = req.req_last[arb_idx];
        grant_id_d = arb_idx;
        state_d = FLUSH;
      end
      FLUSH: state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: if (!tx_busy) begin
        grant_active_d = !last_q;
        rr_ptr_d = last_q ? IW'(wrap_inc(32'(grant_id_q), N_REQ)) : rr_ptr_q;
        cnt_d = '0;
        state_d = last_q ? IDLE : HOLD;
      end
      HOLD: if (req.req_valid[grant_id_q]) begin
        req.req_ready[grant_id_q] = 1'b1;
        data_d = bytes[grant_id_q];
        last_d = req.req_last[grant_id_q];
        state_d = FLUSH;
      end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
        lock_timeout_d = 1'b1;
        grant_active_d = 1'b0;
        rr_ptr_d = IW'(wrap_inc(32'(grant_id_q), N_REQ));
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; reset abandons any lock and leaves the transmitter to finish on its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      grant_active_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      grant_active_q <= grant_active_d;
      data_q <= data_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, cycles a locked owner may idle before lock release.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i in bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  N_REQ  byte is the last of the requester's message.
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot accept strobe; transfer when valid & ready.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter's to_sent.
REQ-010 SHALL have port tx_flush  output  1  one-cycle start strobe to the transmitter's flush.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy.
REQ-012 SHALL have port grant_id  output  clog2(N_REQ)  current or last owner index.
REQ-013 SHALL have port grant_active  output  1  a message is in progress (lock held).
REQ-014 SHALL have port lock_timeout  output  1  one-cycle pulse on forced lock release.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-016 IDLE: when tx_busy=0 and any req_valid, SHALL select the requester by round-robin from rr_ptr, drive its req_ready=1 combinationally that cycle, capture its data/last, set grant_id, and go to FLUSH.
REQ-017 IDLE with tx_busy=1 SHALL assert no req_ready; no flush is issued while the transmitter is busy.
REQ-018 FLUSH: tx_flush=1 for exactly one cycle with tx_data = captured byte; then WAIT_BUSY. tx_flush SHALL never be high for two consecutive cycles, because a held flush stalls the transmitter.
REQ-019 WAIT_BUSY: SHALL wait for tx_busy=1 and then go to WAIT_DONE.
REQ-020 WAIT_DONE: SHALL wait for tx_busy=0. If the captured last=1, SHALL clear grant_active, set rr_ptr=grant_id+1 (mod N_REQ), and go to IDLE. Otherwise SHALL set grant_active=1 and go to HOLD.
REQ-021 HOLD: only the owner is eligible. When owner valid=1, SHALL assert owner req_ready that cycle, capture data/last, and go to FLUSH. Other requesters SHALL receive no ready.
REQ-022 HOLD timeout: counter cleared on HOLD entry. After LOCK_TIMEOUT cycles in HOLD without owner valid, SHALL pulse lock_timeout, clear grant_active, set rr_ptr=owner+1, and go to IDLE.
REQ-023 Latency: a valid seen in IDLE at cycle T SHALL give tx_flush=1 at T+1. Minimum gap between bytes is one cycle after tx_busy falls.
REQ-024 req_ready SHALL be at most one-hot and only asserted in IDLE or HOLD.
REQ-025 Wrap-around: the rr_ptr increment from N_REQ-1 SHALL wrap to 0.
REQ-026 Simultaneous: a valid deassert on the same cycle as ready means no transfer; the FSM SHALL stay in place.

Reset
REQ-027 On rst_n=0 at posedge clk: state=IDLE, rr_ptr=0, grant_id=0, grant_active=0, tx_flush=0, tx_data=0, req_ready=0, lock_timeout=0, timeout counter=0.
REQ-028 Reset mid-frame SHALL abandon the lock. The transmitter is unreset and finishes its frame; REQ-017 gating then prevents overlap.

Structure
REQ-029 The state enum and default-parameter constants SHALL live in shared package uart_pkg.
REQ-030 Round-robin selection SHALL be sub-module rr_arbiter (request vector, pointer in; one-hot grant plus index out, combinational).

Verification
REQ-031 The bench SHALL use the real transmitter with CLKS_PER_BIT=4.
REQ-032 Single byte: req0 sends 0xA5 with last=1 -> tx_flush one cycle later with tx_data=0xA5; serial line shows start, 0xA5 MSB-first; grant_active stays 0.
REQ-033 Fairness: all 4 requesters continuously valid, each byte last=1 -> grant order 0,1,2,3,0; no requester is served twice before another.
REQ-034 Lock: req2 sends 0x11,0x22,0x33 (last on 0x33) while req1 is valid -> the three bytes are transmitted contiguously; req1 is served afterwards.
REQ-035 Timeout: LOCK_TIMEOUT=8; req3 sends 0x7E with last=0 then drops valid -> lock_timeout pulses 8 cycles after HOLD entry; the next grant goes to req0.
REQ-036 Reset mid-frame: rst_n=0 for 2 cycles during WAIT_DONE with req1 valid -> no tx_flush until tx_busy=0; then req0 has priority (rr_ptr=0).
REQ-037 Protocol check: tx_flush is never high on two consecutive cycles and never while tx_busy=1 (assertion).
